// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use stall, counted multiply stall, taken-branch squash.
// Define HAZARD_STALL_COUNT_EN to add the saturating StallCount debug counter.
module hazard_stall_controller #(
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IDEXMemRead,
    input  logic [4:0]  IDEXRt,
    input  logic [4:0]  IFIDRs,
    input  logic [4:0]  IFIDRt,
    input  logic        MultStart,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        MultBusy,
    output logic [1:0]  State
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        UNUSED    = 2'd1,
        MULT_WAIT = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(MULT_LATENCY);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       load_use;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign load_use = IDEXMemRead && (IDEXRt != 5'd0) &&
                      ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (BranchTaken) begin
                        state <= FLUSH;
                    end else if (load_use) begin
                        state <= RUN;
                    end else if (MultStart) begin
                        state    <= MULT_WAIT;
                        wait_cnt <= LAT;
                    end
                end
                MULT_WAIT: begin
                    // A taken branch is older than the multiply, so the multiply is dropped.
                    if (BranchTaken) begin
                        state    <= FLUSH;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt <= 4'd1) begin
                        state    <= RUN;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                FLUSH: begin
                    state <= BranchTaken ? FLUSH : RUN;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        MultBusy   = 1'b0;
        State      = state;
        if (Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            State      = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (BranchTaken) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
                MULT_WAIT: begin
                    if (BranchTaken) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                    end else begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                        MultBusy   = 1'b1;
                    end
                end
                FLUSH: begin
                    IFIDFlush  = 1'b1;
                    IDEXBubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= 32'd0;
        end else if (!PCWrite && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule
